// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF-stage PC/fetch sequencer with HALT drain and branch redirect.
// Optional PC_WRAP_TRAP_EN: RUN at pc 10'h3FF halts instead of wrapping to 10'h000.
module fetch_unit #(
  parameter logic [9:0] START_PC     = 10'd0,
  parameter logic [8:0] HALT_OPCODE  = 9'b111111111,
  parameter logic [8:0] NOP_OPCODE   = 9'b000000000,
  parameter int         DRAIN_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [9:0] branch_target,
  output logic [9:0] imem_addr,
  input  logic [8:0] imem_data,
  output logic [9:0] PC_out,
  output logic [8:0] instr_out,
  output logic       flush_out,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_n;
  logic [9:0] pc, pc_n;
  logic [3:0] drain_cnt, drain_cnt_n;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= START_PC;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drain_cnt_n = drain_cnt;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_n = RUN;
          pc_n    = START_PC;
        end
      end
      RUN: begin
        if (branch_taken) begin
          pc_n = branch_target;
        end else if (stall) begin
          pc_n = pc;
        end else if (imem_data == HALT_OPCODE) begin
          state_n     = DRAIN;
          drain_cnt_n = DRAIN_INIT;
`ifdef PC_WRAP_TRAP_EN
        end else if (pc == 10'h3FF) begin
          state_n = HALTED;
`endif
        end else begin
          pc_n = pc + 10'd1;
        end
      end
      DRAIN: begin
        // A redirect during drain means the HALT was fetched on a wrong path.
        if (branch_taken) begin
          pc_n    = branch_target;
          state_n = RUN;
        end else if (stall) begin
          drain_cnt_n = drain_cnt;
        end else if (drain_cnt == 4'd0) begin
          state_n = HALTED;
        end else begin
          drain_cnt_n = drain_cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign imem_addr = pc;
  assign PC_out    = pc;
  assign running   = (state == RUN) || (state == DRAIN);
  assign done      = (state == HALTED);
  assign instr_out = (state == RUN) ? imem_data : NOP_OPCODE;
  assign flush_out = branch_taken & running;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  localparam logic [8:0] HALT = 9'h1FF;
  localparam logic [8:0] NOP  = 9'h000;

  logic       CLK = 1'b0;
  logic       reset, start, stall, branch_taken;
  logic [9:0] branch_target;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic [9:0] PC_out;
  logic [8:0] instr_out;
  logic       flush_out, running, done;

  logic [8:0] imem [0:1023];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  assign imem_data = imem[imem_addr];

  fetch_unit dut (
    .CLK(CLK), .reset(reset), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .PC_out(PC_out), .instr_out(instr_out), .flush_out(flush_out),
    .running(running), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv;
    @(posedge CLK);
    #1;
  endtask

  // Samples at the falling edge, away from the active edge.
  task automatic expect_st(input string tag, input logic [9:0] pc, input logic [8:0] ins,
                           input logic run, input logic dn);
    @(negedge CLK);
    check({tag, ".pc"}, 32'(PC_out), 32'(pc));
    check({tag, ".addr"}, 32'(imem_addr), 32'(pc));
    check({tag, ".instr"}, 32'(instr_out), 32'(ins));
    check({tag, ".running"}, 32'(running), 32'(run));
    check({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic goto9;
    branch_taken  = 1'b1;
    branch_target = 10'd9;
    adv;
    branch_taken  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 9'(10'h00A + i);
    imem[9] = HALT;

    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 10'd0;
    adv; adv;
    reset = 1'b0;
    expect_st("reset", 10'd0, NOP, 1'b0, 1'b0);
    check("reset.flush", 32'(flush_out), 32'd0);

    // T1: sequential fetch
    start = 1'b1; adv; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_st("t1", 10'(i), 9'(10'h00A + i), 1'b1, 1'b0);
      adv;
    end

    // T2: stall at pc=5
    stall = 1'b1;
    expect_st("t2.s1", 10'd5, 9'h00F, 1'b1, 1'b0); adv;
    expect_st("t2.s2", 10'd5, 9'h00F, 1'b1, 1'b0); adv;
    stall = 1'b0;
    expect_st("t2.rel", 10'd5, 9'h00F, 1'b1, 1'b0); adv;
    expect_st("t2.adv", 10'd6, 9'h010, 1'b1, 1'b0); adv;

    // T3: branch beats stall at pc=7
    stall = 1'b1; branch_taken = 1'b1; branch_target = 10'h120;
    expect_st("t3.br", 10'd7, 9'h011, 1'b1, 1'b0);
    check("t3.flush", 32'(flush_out), 32'd1);
    adv;
    stall = 1'b0; branch_taken = 1'b0;
    start = 1'b1;
    expect_st("t3.tgt", 10'h120, 9'h12A, 1'b1, 1'b0);
    check("t3.noflush", 32'(flush_out), 32'd0);
    adv;
    start = 1'b0;
    expect_st("t3.start_ign", 10'h121, 9'h12B, 1'b1, 1'b0);

    // T4: HALT drains 4 cycles then done
    goto9;
    expect_st("t4.halt", 10'd9, HALT, 1'b1, 1'b0); adv;
    for (int k = 0; k < 4; k++) begin
      expect_st("t4.drain", 10'd9, NOP, 1'b1, 1'b0);
      adv;
    end
    expect_st("t4.done", 10'd9, NOP, 1'b0, 1'b1);
    branch_taken = 1'b1; branch_target = 10'd5; stall = 1'b1;
    #1;
    check("t4.halted_flush", 32'(flush_out), 32'd0);
    adv;
    branch_taken = 1'b0; stall = 1'b0;
    expect_st("t4.hold", 10'd9, NOP, 1'b0, 1'b1);
    start = 1'b1; adv; start = 1'b0;
    expect_st("t4.restart", 10'd0, 9'h00A, 1'b1, 1'b0);

    // T5: redirect in 2nd drain cycle cancels HALT
    goto9;
    expect_st("t5.halt", 10'd9, HALT, 1'b1, 1'b0); adv;
    expect_st("t5.d1", 10'd9, NOP, 1'b1, 1'b0); adv;
    branch_taken = 1'b1; branch_target = 10'd3;
    expect_st("t5.d2", 10'd9, NOP, 1'b1, 1'b0);
    check("t5.flush", 32'(flush_out), 32'd1);
    adv;
    branch_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_st("t5.run", 10'(3 + i), 9'(10'h00D + i), 1'b1, 1'b0);
      adv;
    end

    // Stalled drain cycles do not count
    goto9;
    expect_st("ds.halt", 10'd9, HALT, 1'b1, 1'b0); adv;
    stall = 1'b1;
    expect_st("ds.s1", 10'd9, NOP, 1'b1, 1'b0); adv;
    expect_st("ds.s2", 10'd9, NOP, 1'b1, 1'b0); adv;
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_st("ds.drain", 10'd9, NOP, 1'b1, 1'b0);
      adv;
    end
    expect_st("ds.done", 10'd9, NOP, 1'b0, 1'b1);

    // Reset mid-drain
    start = 1'b1; adv; start = 1'b0;
    goto9;
    expect_st("rd.halt", 10'd9, HALT, 1'b1, 1'b0); adv;
    reset = 1'b1;
    expect_st("rd.drain", 10'd9, NOP, 1'b1, 1'b0); adv;
    reset = 1'b0;
    expect_st("rd.idle", 10'd0, NOP, 1'b0, 1'b0); adv;
    expect_st("rd.idle2", 10'd0, NOP, 1'b0, 1'b0);

    // T6: PC wrap
    start = 1'b1; adv; start = 1'b0;
    branch_taken = 1'b1; branch_target = 10'h3FF; adv; branch_taken = 1'b0;
    expect_st("t6.top", 10'h3FF, 9'h009, 1'b1, 1'b0); adv;
`ifdef PC_WRAP_TRAP_EN
    expect_st("t6.trap", 10'h3FF, NOP, 1'b0, 1'b1);
`else
    expect_st("t6.wrap", 10'h000, 9'h00A, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
